pc_fetch_unit: RTL and testbench

- Owns the program counter and the instruction-fetch handshake.
- Sits directly downstream of the PC-source controller. It consumes the 2-bit pc_src select and computes the next PC: sequential, PC-relative (branch/jal), or register-indirect (jalr).
- It fetches the instruction at PC from instruction memory over a valid/ready request and a valid response, then holds it for decode until the consumer accepts it.
- Traps on a misaligned target.

---
 rtl/pc_fetch_unit.sv | 129 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter owner and instruction-fetch handshake.
//               Computes the next PC, traps on a misaligned target.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic             stall,
    input  logic             instr_ready,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr_pc,
    output logic [WIDTH-1:0] pc,
    output logic             trap,
    output logic [WIDTH-1:0] trap_addr
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_TRAP = 3'd4;

    logic [2:0]       state_q,       state_d;
    logic [WIDTH-1:0] pc_q,          pc_d;
    logic [31:0]      instr_q,       instr_d;
    logic [WIDTH-1:0] instr_pc_q,    instr_pc_d;
    logic             instr_valid_q, instr_valid_d;
    logic             trap_q,        trap_d;
    logic [WIDTH-1:0] trap_addr_q,   trap_addr_d;
    logic [WIDTH-1:0] next_pc;

    // Reserved select 11 falls through to the sequential case.
    always_comb begin
        next_pc = pc_q + WIDTH'(4);
        case (pc_src)
            2'b01:   next_pc = pc_q + imm;
            2'b10:   next_pc = (rs1_data + imm) & ~WIDTH'(1);
            default: next_pc = pc_q + WIDTH'(4);
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        trap_d        = trap_q;
        trap_addr_d   = trap_addr_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d       = imem_rsp_data;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                // Stall wins over instr_ready.
                if (instr_ready && !stall) begin
                    instr_valid_d = 1'b0;
                    if (next_pc[1:0] != 2'b00) begin
                        trap_d      = 1'b1;
                        trap_addr_d = next_pc;
                        state_d     = S_TRAP;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            trap_q        <= 1'b0;
            trap_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            trap_q        <= trap_d;
            trap_addr_q   <= trap_addr_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_valid    = instr_valid_q;
    assign trap           = trap_q;
    assign trap_addr      = trap_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Scoreboard bench for pc_fetch_unit with a simple memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] imm = '0;
    logic [31:0] rs1_data = '0;
    logic        stall = 1'b0;
    logic        instr_ready = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic        trap;
    logic [31:0] trap_addr;

    int n_cmp = 0;
    int n_err = 0;

    bit  mem_en  = 1'b0;
    bit  man_rsp = 1'b0;
    int  rdy_dly = 0;
    int  rsp_dly = 0;
    logic [63:0] exp_q [$];

    pc_fetch_unit #(.WIDTH(32), .RESET_PC(C_RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .imm(imm), .rs1_data(rs1_data),
        .stall(stall), .instr_ready(instr_ready), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc), .pc(pc),
        .trap(trap), .trap_addr(trap_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Memory model: accepts a request after rdy_dly cycles, answers rsp_dly cycles later.
    initial begin
        int          phase = 0;
        int          cnt = 0;
        logic [31:0] lat_addr = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (!mem_en || !rst_n) begin
                phase = 0;
                cnt   = 0;
                imem_rsp_valid = man_rsp;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end else if (phase == 0) begin
                if (imem_req_valid) begin
                    if (cnt >= rdy_dly) begin
                        imem_req_ready = 1'b1;
                        lat_addr = imem_addr;
                        phase = 1;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                if (cnt >= rsp_dly) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(lat_addr);
                    phase = 0;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Monitor: every newly presented instruction is checked against the queue head.
    initial begin
        logic        prev_v = 1'b0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_instr_pc", instr_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e[63:32]);
                    check("instr", instr, e[31:0]);
                end
            end
            prev_v = instr_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!instr_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (!instr_valid) check("valid_timeout", 32'(instr_valid), 32'd1);
    endtask

    // Called at a negedge with an instruction held; accepts it and follows the next fetch.
    task automatic accept(input logic [1:0] src, input logic [31:0] im, input logic [31:0] rs,
                          input logic [31:0] nxt, input int req_chk, input int lat);
        int c = 0;
        int w;
        pc_src = src; imm = im; rs1_data = rs; instr_ready = 1'b1; stall = 1'b0;
        exp_q.push_back({nxt, mem_word(nxt)});
        @(negedge clk);
        instr_ready = 1'b0;
        check("next_pc", pc, nxt);
        check("valid_fall", 32'(instr_valid), 32'd0);
        for (int i = 0; i < req_chk; i++) begin
            check("req_held", 32'(imem_req_valid), 32'd1);
            check("req_addr_stable", imem_addr, nxt);
            @(negedge clk);
            c++;
        end
        wait_valid(w);
        check("fetch_latency", 32'(c + w), 32'(lat));
    endtask

    initial begin
        int w;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pc", pc, C_RESET_PC);
        check("rst_imem_addr", imem_addr, C_RESET_PC);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_trap_addr", trap_addr, 32'd0);

        mem_en = 1'b1;
        exp_q.push_back({C_RESET_PC, mem_word(C_RESET_PC)});
        rst_n = 1'b1;
        wait_valid(w);

        // Sequential stream, then relative and register-indirect jumps
        accept(2'b00, 32'h0,         32'h0,    32'h0000_0104, 0, 2);
        accept(2'b11, 32'h0,         32'h0,    32'h0000_0108, 0, 2);
        accept(2'b01, 32'h0000_00F8, 32'h0,    32'h0000_0200, 0, 2);
        accept(2'b01, 32'hFFFF_FFF0, 32'h0,    32'h0000_01F0, 0, 2);
        accept(2'b10, 32'h0000_0003, 32'h1001, 32'h0000_1004, 0, 2);

        // Stall has priority over instr_ready
        pc_src = 2'b00; instr_ready = 1'b1; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_pc", pc, 32'h0000_1004);
            check("stall_instr", instr, mem_word(32'h0000_1004));
            check("stall_valid", 32'(instr_valid), 32'd1);
        end
        accept(2'b00, 32'h0, 32'h0, 32'h0000_1008, 0, 2);

        // Slow memory: ready after 3 cycles, response 5 cycles later
        rdy_dly = 3; rsp_dly = 5;
        accept(2'b01, 32'hFFFF_F038, 32'h0, 32'h0000_0040, 3, 10);
        rdy_dly = 0; rsp_dly = 0;

        // Wrap-around
        accept(2'b01, 32'hFFFF_FFBC, 32'h0, 32'hFFFF_FFFC, 0, 2);
        accept(2'b00, 32'h0,         32'h0, 32'h0000_0000, 0, 2);
        accept(2'b01, 32'h0000_0040, 32'h0, 32'h0000_0040, 0, 2);

        // Misaligned target traps
        pc_src = 2'b01; imm = 32'h2; instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("trap_set", 32'(trap), 32'd1);
        check("trap_addr", trap_addr, 32'h0000_0042);
        check("trap_pc", pc, 32'h0000_0040);
        check("trap_valid", 32'(instr_valid), 32'd0);
        pc_src = 2'b00; instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("trap_no_req", 32'(imem_req_valid), 32'd0);
            check("trap_sticky", 32'(trap), 32'd1);
        end
        instr_ready = 1'b0;

        // Asynchronous reset clears the trap
        rst_n = 1'b0;
        #1;
        check("trap_rst_trap", 32'(trap), 32'd0);
        check("trap_rst_addr", trap_addr, 32'd0);
        check("trap_rst_pc", pc, C_RESET_PC);
        @(negedge clk);
        exp_q.push_back({C_RESET_PC, mem_word(C_RESET_PC)});
        rst_n = 1'b1;
        wait_valid(w);

        // Reset mid-WAIT; a late response after release must be discarded
        rsp_dly = 20; pc_src = 2'b00; instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        @(negedge clk);
        check("wait_no_req", 32'(imem_req_valid), 32'd0);
        mem_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midwait_rst_pc", pc, C_RESET_PC);
        check("midwait_rst_req", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        rsp_dly = 0;
        rst_n = 1'b1;
        man_rsp = 1'b1;
        @(negedge clk);
        @(negedge clk);
        man_rsp = 1'b0;
        check("late_rsp_req", 32'(imem_req_valid), 32'd1);
        check("late_rsp_valid", 32'(instr_valid), 32'd0);
        check("late_rsp_pc", pc, C_RESET_PC);
        exp_q.push_back({C_RESET_PC, mem_word(C_RESET_PC)});
        mem_en = 1'b1;
        wait_valid(w);
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
